// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin sharing of one shift-add multiplier among N_REQ requesters
// Optional MULT_SHARE_EARLY_TERM_EN: finish CALC as soon as the remaining multiplier bits are zero.
module mult_share_ctrl #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_prod,
    input  logic                   rsp_ready,
    output logic                   busy
);

    localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      cur_id;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   a_sh;
    logic [2*WIDTH-1:0]   p_reg;
    logic [2*WIDTH-1:0]   p_next;
    logic [STEP_W-1:0]    step;
    logic                 last_step;

    logic                 found;
    logic                 found_hi;
    logic [ID_W-1:0]      win;
    logic [ID_W-1:0]      win_hi;
    logic [ID_W-1:0]      win_lo;
    logic [ID_W-1:0]      rr_next;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        found    = 1'b0;
        found_hi = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                found  = 1'b1;
                win_lo = ID_W'(j);
                if (ID_W'(j) >= rr_ptr) begin
                    found_hi = 1'b1;
                    win_hi   = ID_W'(j);
                end
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        if (win == ID_W'(N_REQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = win + 1'b1;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (win == ID_W'(j)) begin
                sel_a = req_a[j*WIDTH +: WIDTH];
                sel_b = req_b[j*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by rst_n so that no grant is offered while reset is held.
    always_comb begin
        req_ready = '0;
        for (int j = 0; j < N_REQ; j++) begin
            req_ready[j] = rst_n && (state == IDLE) && found && (win == ID_W'(j));
        end
    end

    always_comb begin
        p_next = p_reg + (b_reg[0] ? a_sh : '0);
`ifdef MULT_SHARE_EARLY_TERM_EN
        last_step = (step == LAST_STEP) || ((b_reg >> 1) == '0);
`else
        last_step = (step == LAST_STEP);
`endif
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            b_reg     <= '0;
            a_sh      <= '0;
            p_reg     <= '0;
            step      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        a_sh   <= {{WIDTH{1'b0}}, sel_a};
                        b_reg  <= sel_b;
                        cur_id <= win;
                        p_reg  <= '0;
                        step   <= '0;
                        rr_ptr <= rr_next;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // a_sh carries A shifted left by the current step index.
                    p_reg <= p_next;
                    a_sh  <= a_sh << 1;
                    b_reg <= b_reg >> 1;
                    step  <= step + 1'b1;
                    if (last_step) begin
                        rsp_prod  <= p_next;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - self-checking bench for mult_share_ctrl
module tb_mult_share_ctrl;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;
`ifdef MULT_SHARE_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_prod;
    logic                   rsp_ready;
    logic                   busy;

    always #5 clk = ~clk;

    mult_share_ctrl #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] va [N_REQ];
    logic [WIDTH-1:0] vb [N_REQ];

    // Reference model: one operation in flight, countdown to response, rr pointer as an integer.
    int m_rr = 0;
    bit m_busy = 0;
    bit m_done = 0;
    int m_rem = 0;
    int m_id = 0;
    logic [2*WIDTH-1:0] m_prod = '0;
    int m_grant = -1;

    // Observations of the DUT used for the literal expectations.
    int edge_cnt = 0;
    int acc_edge = 0;
    int lat_obs = 0;
    int got_id = 0;
    logic [2*WIDTH-1:0] got_prod = '0;
    int got_cnt = 0;
    int dut_grants[$];
    bit prev_valid = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for DUT (t=%0t)", name, $time);
    endtask

    function automatic int exp_lat(input logic [WIDTH-1:0] b);
        int l;
        l = WIDTH;
        if (ET) begin
            l = 1;
            for (int i = 0; i < WIDTH; i++) if (b[i]) l = i + 1;
        end
        return l;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom % 8)
            0: return '0;
            1: return WIDTH'(1);
            2: return WIDTH'(8'h80);
            3: return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic check_and_update();
        logic [N_REQ-1:0] e_ready;
        int w;
        if ((req_valid & req_ready) != '0) begin
            for (int i = 0; i < N_REQ; i++) if (req_valid[i] && req_ready[i]) dut_grants.push_back(i);
            acc_edge = edge_cnt + 1;
        end
        if (rsp_valid && !prev_valid) lat_obs = edge_cnt - acc_edge;
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            got_id = int'(rsp_id);
            got_prod = rsp_prod;
            got_cnt++;
        end
        m_grant = -1;
        if (!rst_n) begin
            chk("reset_req_ready", req_ready, 0);
            chk("reset_rsp_valid", rsp_valid, 0);
            chk("reset_rsp_id", rsp_id, 0);
            chk("reset_rsp_prod", rsp_prod, 0);
            chk("reset_busy", busy, 0);
            m_rr = 0; m_busy = 0; m_done = 0; m_rem = 0;
            return;
        end
        e_ready = '0;
        w = -1;
        if (!m_busy && !m_done) begin
            for (int k = 0; k < N_REQ; k++) begin
                int idx;
                idx = (m_rr + k) % N_REQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        if (w >= 0) e_ready[w] = 1'b1;
        chk("req_ready", req_ready, e_ready);
        chk("busy", busy, m_busy || m_done);
        chk("rsp_valid", rsp_valid, m_done);
        if (m_done) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_prod", rsp_prod, m_prod);
        end
        if (m_done) begin
            if (rsp_ready) m_done = 0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (w >= 0) begin
            m_busy = 1;
            m_rem = exp_lat(vb[w]);
            m_id = w;
            m_prod = {{WIDTH{1'b0}}, va[w]} * {{WIDTH{1'b0}}, vb[w]};
            m_rr = (w + 1) % N_REQ;
            m_grant = w;
        end
    endtask

    task automatic tick();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = va[i];
            req_b[i*WIDTH +: WIDTH] = vb[i];
        end
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input int a, input int b);
        bit ok;
        ok = 0;
        va[i] = WIDTH'(a);
        vb[i] = WIDTH'(b);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            tick();
            if (m_grant == i) ok = 1;
        end
        req_valid[i] = 1'b0;
        if (!ok) timeout("issue_grant");
    endtask

    task automatic wait_rsp();
        int start;
        start = got_cnt;
        for (int n = 0; n < 100 && got_cnt == start; n++) tick();
        if (got_cnt == start) timeout("wait_rsp");
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int n = 0; n < 100 && (m_busy || m_done); n++) tick();
        if (m_busy || m_done) timeout("drain");
    endtask

    initial begin
        int g0;
        int n;
        int start;
        for (int i = 0; i < N_REQ; i++) begin
            va[i] = WIDTH'(i + 1);
            vb[i] = WIDTH'(i + 2);
        end
        req_valid = '1;
        rsp_ready = 1'b0;
        #1;
        repeat (3) tick();
        req_valid = '0;
        rst_n = 1'b1;

        // Requester 0: 13*11
        rsp_ready = 1'b1;
        issue(0, 13, 11);
        wait_rsp();
        chk("t1_prod", got_prod, 143);
        chk("t1_id", got_id, 0);
        chk("t1_lat", lat_obs, ET ? 4 : 8);

        // Requester 2: 255*255 and 0*200
        issue(2, 255, 255);
        wait_rsp();
        chk("t2_prod", got_prod, 16'hFE01);
        chk("t2_id", got_id, 2);
        chk("t2_lat", lat_obs, 8);
        issue(2, 0, 200);
        wait_rsp();
        chk("t2b_prod", got_prod, 0);
        chk("t2b_lat", lat_obs, 8);

        // All requesters valid from reset: grants 0,1,2,3,0
        rst_n = 1'b0;
        tick();
        tick();
        for (int i = 0; i < N_REQ; i++) begin
            va[i] = WIDTH'(10 + i);
            vb[i] = WIDTH'(20 + 3 * i);
        end
        req_valid = '1;
        dut_grants.delete();
        start = got_cnt;
        rst_n = 1'b1;
        for (int k = 0; k < 300 && got_cnt - start < 5; k++) begin
            tick();
            if (m_grant >= 0) begin
                va[m_grant] = rnd_op();
                vb[m_grant] = rnd_op();
            end
        end
        if (got_cnt - start < 5) timeout("t3_responses");
        req_valid = '0;
        chk("t3_ngrants_ge5", dut_grants.size() >= 5, 1);
        if (dut_grants.size() >= 5)
            for (int k = 0; k < 5; k++) chk("t3_grant_order", dut_grants[k], k % N_REQ);
        drain();

        // Backpressure in DONE for 5 cycles
        rsp_ready = 1'b0;
        issue(1, 100, 3);
        for (n = 0; n < 20 && !m_done; n++) tick();
        if (!m_done) timeout("t4_done");
        va[3] = 7;
        vb[3] = 9;
        req_valid[3] = 1'b1;
        repeat (5) tick();
        chk("t4_held_prod", rsp_prod, 300);
        rsp_ready = 1'b1;
        g0 = dut_grants.size();
        for (n = 0; n < 10 && dut_grants.size() == g0; ) begin
            tick();
            n++;
        end
        req_valid[3] = 1'b0;
        chk("t4_gap", n, 2);
        chk("t4_consumed_prod", got_prod, 300);
        chk("t4_consumed_id", got_id, 1);
        wait_rsp();
        chk("t4_next_prod", got_prod, 63);
        chk("t4_next_id", got_id, 3);

        // Asynchronous reset at CALC step 4 with requester 1 in flight
        issue(1, 9, 7);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_valid", rsp_valid, 0);
        chk("t5_async_ready", req_ready, 0);
        tick();
        tick();
        va[0] = 5; vb[0] = 6; va[1] = 11; vb[1] = 13;
        req_valid = 4'b0011;
        dut_grants.delete();
        rst_n = 1'b1;
        for (n = 0; n < 20 && dut_grants.size() == 0; n++) tick();
        req_valid = '0;
        if (dut_grants.size() == 0) timeout("t5_grant");
        else chk("t5_first_grant", dut_grants[0], 0);
        wait_rsp();
        chk("t5_prod", got_prod, 30);
        chk("t5_id", got_id, 0);

`ifdef MULT_SHARE_EARLY_TERM_EN
        issue(0, 77, 1);
        wait_rsp();
        chk("et_b1_prod", got_prod, 77);
        chk("et_b1_lat", lat_obs, 1);
        issue(0, 3, 8'h80);
        wait_rsp();
        chk("et_b80_prod", got_prod, 384);
        chk("et_b80_lat", lat_obs, 8);
        issue(0, 5, 0);
        wait_rsp();
        chk("et_b0_prod", got_prod, 0);
        chk("et_b0_lat", lat_obs, 1);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            tick();
            for (int i = 0; i < N_REQ; i++) begin
                if (m_grant == i) begin
                    req_valid[i] = 1'($urandom % 2);
                    va[i] = rnd_op();
                    vb[i] = rnd_op();
                end else if (req_valid[i]) begin
                    if ($urandom % 16 == 0) req_valid[i] = 1'b0;
                end else if ($urandom % 4 == 0) begin
                    req_valid[i] = 1'b1;
                    va[i] = rnd_op();
                    vb[i] = rnd_op();
                end
            end
            rsp_ready = ($urandom % 4) != 0;
        end
        req_valid = '0;
        drain();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
